// File: rtl/prio_rr_arbiter.sv
// -----------------------------------------------------------------------------
// prio_rr_arbiter
//
// Packet-level arbiter that merges NUM_REQ beat streams onto one shared output.
// A winner is picked in IDLE (fixed priority or round-robin, chosen by `mode`),
// registered into `grant`, and then owns the output until its last beat has
// transferred. Every release is followed by one IDLE cycle before the next
// grant.
//
// Handshake: a beat moves across an interface on a rising clk edge where that
// interface's valid and ready are both high. Valid never depends on ready.
// On the upstream side req_ready is simply out_ready routed to the owner, so
// req_valid[i] && req_ready[i] is the same event as out_valid && out_ready.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = fixed priority (index 0 highest), 1 = round-robin;
//                   looked at only while arbitrating in IDLE
//   req_valid  in   [NUM_REQ]          per-requester beat valid
//   req_data   in   [NUM_REQ*DATA_W]   requester i at [i*DATA_W +: DATA_W]
//   req_last   in   [NUM_REQ]          per-requester last-beat flag
//   req_ready  out  [NUM_REQ]          per-requester beat accept
//   out_valid  out  shared-output beat valid
//   out_data   out  [DATA_W] shared-output data
//   out_last   out  shared-output last flag
//   out_ready  in   downstream accept
//   grant      out  [NUM_REQ] one-hot owner, all-zero when idle
//   busy       out  high while in GRANT (the FSM state, exposed for checkers)
// -----------------------------------------------------------------------------
module prio_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;    // binary index of grant_q
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;  // first index searched in RR

    // -------------------------------------------------------------------------
    // Winner selection (only consumed in IDLE)
    // -------------------------------------------------------------------------
    logic                 any_req;
    logic [PTR_W-1:0]     fixed_idx;
    logic [PTR_W-1:0]     rr_idx;
    logic                 rr_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W:0]       ptr_after_win;

    assign any_req = |req_valid;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        fixed_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[PTR_W'(i)]) begin
                fixed_idx = PTR_W'(i);
            end
        end
    end

    // Search upward from rr_ptr_q with wrap. The sum is one bit wider than the
    // pointer so non-power-of-two NUM_REQ wraps correctly.
    always_comb begin
        logic [PTR_W:0] cand;
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (!rr_found && req_valid[cand[PTR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign win_idx = mode ? rr_idx : fixed_idx;

    // Pointer reload value (winner + 1) mod NUM_REQ, applied in both modes so a
    // switch to round-robin starts just after whoever was served last.
    always_comb begin
        ptr_after_win = {1'b0, win_idx} + (PTR_W + 1)'(1);
        if (ptr_after_win == (PTR_W + 1)'(NUM_REQ)) begin
            ptr_after_win = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Owner view of the request side
    // -------------------------------------------------------------------------
    logic                 owner_valid;
    logic                 owner_last;
    logic [DATA_W-1:0]    owner_data;
    logic                 beat_fire;

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_data  = req_data[owner_q * DATA_W +: DATA_W];

    assign beat_fire   = (state_q == S_GRANT) && owner_valid && out_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d  = S_GRANT;
                    grant_d  = NUM_REQ'(1) << win_idx;
                    owner_d  = win_idx;
                    rr_ptr_d = ptr_after_win[PTR_W-1:0];
                end
            end
            S_GRANT: begin
                // Owner stalls (req_valid low) simply hold here; only a
                // transferred last beat releases the output. Leaving through
                // IDLE gives the mandatory one-cycle gap between owners.
                if (beat_fire && owner_last) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // All output gating keys off registered state, so an asynchronous reset
    // clears them immediately and they are quiet in IDLE.
    assign busy      = (state_q == S_GRANT);
    assign grant     = grant_q;
    assign out_valid = busy && owner_valid;
    assign out_last  = busy && owner_last;
    assign out_data  = busy ? owner_data : '0;
    // grant_q is zero in IDLE, so this also keeps every req_ready low there.
    assign req_ready = grant_q & {NUM_REQ{out_ready}};

    // -------------------------------------------------------------------------
    // Embedded checks
    // -------------------------------------------------------------------------
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));

    a_busy_matches_grant : assert property (@(posedge clk) disable iff (!rst_n)
        busy == (grant_q != '0));

    a_owner_matches_grant : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> grant_q[owner_q]);

    // After a release the next cycle is always IDLE.
    a_idle_gap : assert property (@(posedge clk) disable iff (!rst_n)
        (busy && beat_fire && owner_last) |=> !busy);

endmodule

// File: doc/prio_rr_arbiter.md
PRIO_RR_ARBITER -- requirements
Module: prio_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2 to 8.
REQ-002 SHALL have parameter DATA_W, default 8: data width per requester.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mode  input  1  arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_last  input  NUM_REQ  per-requester last-beat-of-packet flag.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester beat accept.
REQ-010 SHALL have port out_valid  output  1  shared-output beat valid.
REQ-011 SHALL have port out_data  output  DATA_W  shared-output data.
REQ-012 SHALL have port out_last  output  1  shared-output last flag.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-015 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-016 SHALL implement two states: IDLE and GRANT.
REQ-017 In IDLE with any req_valid high, the arbiter SHALL select a winner, register it into grant and enter GRANT on the next edge; arbitration latency is 1 cycle.
REQ-018 Fixed mode SHALL select the lowest-index requester with req_valid high.
REQ-019 Round-robin mode SHALL select the first requester with req_valid high, searching upward from pointer rr_ptr with wrap from NUM_REQ-1 to 0.
REQ-020 On every grant, in either mode, rr_ptr SHALL load (winner+1) mod NUM_REQ.
REQ-021 mode SHALL be sampled only in IDLE; a change during GRANT SHALL have no effect until the next arbitration.
REQ-022 In GRANT, out_valid, out_data and out_last SHALL combinationally equal the granted requester's req_valid, data slice and req_last.
REQ-023 In GRANT, the granted requester's req_ready SHALL equal out_ready; all other req_ready bits SHALL be 0.
REQ-024 In IDLE, out_valid and all req_ready bits SHALL be 0, and out_data and out_last SHALL be 0.
REQ-025 A beat SHALL transfer on a cycle with out_valid and out_ready both high.
REQ-026 The grant SHALL be held until a beat with out_last=1 transfers; the state SHALL then return to IDLE on that edge.
REQ-027 After each release there SHALL be exactly one IDLE cycle before any new grant (no back-to-back grant).
REQ-028 If the owner drops req_valid mid-packet, the grant SHALL be held, with out_valid low, until the owner resumes and completes its packet.
REQ-029 Requests from non-owners during GRANT SHALL be ignored and SHALL not be dropped; they are re-evaluated in the next IDLE cycle.
REQ-030 A single-beat packet (req_last=1 on the first beat) SHALL occupy one GRANT cycle if out_ready=1.

Reset
REQ-031 Reset assertion SHALL asynchronously force state=IDLE, grant=0, rr_ptr=0 and busy=0; out_valid, req_ready and out_last SHALL then be 0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no further beats; after release the arbiter SHALL arbitrate afresh from rr_ptr=0.
REQ-033 Outputs SHALL be stable and defined on the first rising clk edge after rst_n rises; no internal reset synchroniser is required.

Verification
REQ-034 Fixed mode, req_valid=4'b1010 held, each requester sending 1-beat packets, out_ready=1 -> grant sequence 0010, 0010, ...: requester 3 is starved; each grant is separated by one IDLE cycle.
REQ-035 Round-robin mode, req_valid=4'b1111 held, 1-beat packets -> grant order 0001, 0010, 0100, 1000, 0001, which checks the wrap.
REQ-036 Requester 2 sends a 3-beat packet with data 0x11, 0x22, 0x33 while out_ready toggles 1, 0, 1, 1 -> out_data shows 0x11, 0x22, 0x22, 0x33, with 3 transfers; release occurs after 0x33; req_ready[2] tracks out_ready throughout.
REQ-037 Owner 1 drops req_valid for 2 cycles mid-packet while requester 0 requests -> grant stays 0010 with out_valid=0; requester 0 is granted only after requester 1's last beat plus one IDLE cycle.
REQ-038 rst_n pulled low during beat 2 of 4 -> grant=0 and out_valid=0 immediately, without waiting for a clock edge; after release with req_valid=4'b1000 in round-robin mode, grant becomes 1000 one cycle later.
